pipelined_cpu: RTL and testbench
================================

# pipelined_cpu

Five-stage in-order pipelined 32-bit MIPS-subset processor (IF, ID, EX, MEM, WB) with its own instruction memory, data memory and register file. It is the top-level compute block of the project. A bench preloads the memories and register file hierarchically, then releases reset and asserts start. The core handles data hazards by forwarding and a load-use stall, and resolves branches and jumps in ID with a one-slot flush.

## Interface
- No parameters. Memory sizes are fixed:
  - instruction memory: 256 × 32-bit words
  - data memory: 32 × 8-bit bytes
  - register file: 32 × 32-bit
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  run enable; PC advances only while high.
- Bench-visible internals, required for hierarchical access:
  - instance Instruction_Memory, array memory[0:255]
  - instance DATAMEMORY, byte array out[0:31]
  - instance Registers, array register[0:31]
  - instance PC, output pc_o
  - instance HD, output mux8_o
  - instance Control, outputs jump_o and branch_o
  - instance EQ, output data_o

## Operation
- ISA uses standard MIPS encodings:
  - R-type (opcode 0) with funct: add 0x20, sub 0x22, and 0x24, or 0x25, mul 0x18 (low 32 bits of the product).
  - addi 0x08 (sign-extended imm), lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Any other opcode executes as a NOP, with no register or memory write.
- Instruction memory: word-indexed by PC[9:2]; combinational read.
- Data memory: byte address = ALU result[4:0], little-endian. A word at address A is {out[A+3], out[A+2], out[A+1], out[A]}. Reads are combinational; sw writes all 4 bytes at the clock edge.
- Register file:
  - two combinational read ports, one write port at the edge
  - writes to r0 ignored; r0 always reads 0
  - write-through: a read of the register being written in WB returns the new value
- Forwarding into EX operands: EX/MEM result has priority over MEM/WB result. Only a destination that is nonzero with RegWrite set is forwarded.
- Load-use hazard (HD): a lw in EX whose rt equals the ID instruction's rs or rt, with rt≠0:
  - hold PC and IF/ID
  - zero the ID/EX control fields, i.e. insert a bubble
  - mux8_o=0 during the stall, 1 otherwise
- Branch (beq):
  - compare happens in ID; EQ.data_o = (rs value == rt value), using register-file values only
  - no forwarding into ID; software inserts NOPs for branch-operand hazards
  - if taken: PC ← PC_ID+4 + (sext(imm)<<2), and the instruction in IF is flushed, i.e. IF/ID becomes a NOP
- Jump (j): PC ← {PC_ID+4[31:28], target, 2'b00}; IF/ID is flushed.
- Priority when both apply: the load-use stall overrides a branch or jump decision in the same cycle. The branch or jump re-evaluates after the bubble.
- start_i low: PC holds, IF/ID loads a NOP, and later stages drain normally.

## Timing
- Reset, on the rising edge with rst_i=1:
  - PC=0
  - all pipeline registers and their control fields cleared to NOP
  - instruction memory, data memory and register file contents are not altered by reset
- PC advances by 4 per cycle when start_i=1 and there is no stall or redirect.
- Latency: an instruction fetched at edge k writes the register file at edge k+4. An sw writes memory at edge k+3.
- A back-to-back dependent ALU pair needs no stall.
- lw followed immediately by a user of its result costs exactly 1 stall cycle.
- Taken beq or j costs exactly 1 flushed slot. An untaken beq costs 0.
- rst_i asserted mid-program: on the next edge the pipeline is emptied and fetch restarts at 0. Writes in flight are discarded.

## Test plan
- Reset and start:
  - stimulus: rst_i=1 for one edge, then start_i=1 over NOPs
  - required: PC reads 0, 4, 8, 12 on successive cycles; with start_i=0, PC stays constant.
- Forwarding:
  - stimulus: addi t0,r0,5; addi t1,r0,3; add t2,t0,t1; sub t3,t2,t0
  - required: t2=8, t3=3, zero stalls.
- Load-use:
  - stimulus: data mem out[0]=5; lw t0,0(r0); add t1,t0,t0
  - required: exactly one cycle with HD.mux8_o=0, then t1=10.
- Branch and jump:
  - stimulus: beq r0,r0,+1 over a skipped addi s0,r0,7, followed by j to a later address
  - required: s0 stays 0; two flushes total; PC lands on both targets.
- Store/load:
  - stimulus: t0=0x12345678; sw t0,4(r0); lw t1,4(r0)
  - required: out[4]=0x78, out[7]=0x12, t1=0x12345678.
- mul and r0:
  - stimulus: mul s1,t0,t1 with t0=5, t1=3; then addi r0,r0,9
  - required: s1=15; r0 remains 0.

Source files
------------

// File: rtl/pipelined_cpu.sv
// pipelined_cpu: five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB)
// with private instruction memory, data memory and register file.
// Hazards: EX-stage forwarding, one-cycle load-use stall, branch/jump
// resolved in ID with a single flushed fetch slot.

// Program counter; holds on stall or when not enabled, redirects on taken branch/jump.
module PC (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_en,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic [31:0] pc_o
);
  // PC register update
  always_ff @(posedge clk_i) begin
    if (rst_i)           pc_o <= 32'd0;
    else if (i_en)       pc_o <= i_redirect ? i_target : pc_o + 32'd4;
  end
endmodule

// 256-word instruction ROM with a loader write port (tied off in the core).
module Instruction_Memory (
  input  logic        clk_i,
  input  logic        i_we,
  input  logic [7:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [7:0]  i_raddr,
  output logic [31:0] o_data
);
  logic [31:0] memory [0:255];

  // optional preload path; contents survive reset
  always_ff @(posedge clk_i) begin
    if (i_we) memory[i_waddr] <= i_wdata;
  end

  assign o_data = memory[i_raddr];
endmodule

// 32 x 32 register file, r0 hard-wired to zero, write-through on read.
module Registers (
  input  logic        clk_i,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] register [0:31];

  // single write port; r0 is never written
  always_ff @(posedge clk_i) begin
    if (i_we && i_wa != 5'd0) register[i_wa] <= i_wd;
  end

  // reads see the value being written back in the same cycle
  always_comb begin
    o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : register[i_ra1];
    o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : register[i_ra2];
    if (i_we && i_wa != 5'd0 && i_wa == i_ra1) o_rd1 = i_wd;
    if (i_we && i_wa != 5'd0 && i_wa == i_ra2) o_rd2 = i_wd;
  end
endmodule

// 32-byte little-endian data memory, combinational word read, word write.
module DATAMEMORY (
  input  logic        clk_i,
  input  logic [4:0]  i_addr,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0] out [0:31];
  logic [4:0] w_a1, w_a2, w_a3;

  assign w_a1 = i_addr + 5'd1;
  assign w_a2 = i_addr + 5'd2;
  assign w_a3 = i_addr + 5'd3;

  // store all four bytes of a word
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      out[i_addr] <= i_wdata[7:0];
      out[w_a1]   <= i_wdata[15:8];
      out[w_a2]   <= i_wdata[23:16];
      out[w_a3]   <= i_wdata[31:24];
    end
  end

  assign o_rdata = {out[w_a3], out[w_a2], out[w_a1], out[i_addr]};
endmodule

// Main decoder. Unsupported opcodes/functs decode to all-zero controls (NOP).
module Control (
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic       o_regwrite,
  output logic       o_memtoreg,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_alusrc,
  output logic       o_regdst,
  output logic [2:0] o_aluop,
  output logic       branch_o,
  output logic       jump_o
);
  // opcode/funct decode; aluop: 0 add, 1 sub, 2 and, 3 or, 4 mul
  always_comb begin
    o_regwrite = 1'b0;
    o_memtoreg = 1'b0;
    o_memread  = 1'b0;
    o_memwrite = 1'b0;
    o_alusrc   = 1'b0;
    o_regdst   = 1'b0;
    o_aluop    = 3'd0;
    branch_o   = 1'b0;
    jump_o     = 1'b0;
    case (i_op)
      6'h00: begin
        o_regdst = 1'b1;
        case (i_funct)
          6'h20: begin o_regwrite = 1'b1; o_aluop = 3'd0; end
          6'h22: begin o_regwrite = 1'b1; o_aluop = 3'd1; end
          6'h24: begin o_regwrite = 1'b1; o_aluop = 3'd2; end
          6'h25: begin o_regwrite = 1'b1; o_aluop = 3'd3; end
          6'h18: begin o_regwrite = 1'b1; o_aluop = 3'd4; end
          default: o_regdst = 1'b0;
        endcase
      end
      6'h08: begin o_regwrite = 1'b1; o_alusrc = 1'b1; end
      6'h23: begin o_regwrite = 1'b1; o_alusrc = 1'b1; o_memread = 1'b1; o_memtoreg = 1'b1; end
      6'h2B: begin o_alusrc = 1'b1; o_memwrite = 1'b1; end
      6'h04: branch_o = 1'b1;
      6'h02: jump_o   = 1'b1;
      default: ;
    endcase
  end
endmodule

// Register-value equality for beq resolution in ID.
module EQ (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        data_o
);
  assign data_o = (i_a == i_b);
endmodule

// Load-use hazard detector; mux8_o low means stall and bubble.
module HD (
  input  logic       i_idex_memread,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  output logic       mux8_o
);
  assign mux8_o = ~(i_idex_memread && i_idex_rt != 5'd0 &&
                    (i_idex_rt == i_ifid_rs || i_idex_rt == i_ifid_rt));
endmodule

module pipelined_cpu (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);
  // ---------------- IF ----------------
  logic [31:0] w_pc, w_if_instr, w_target;
  logic        w_redirect, w_nostall;

  // ---------------- IF/ID ----------------
  logic [31:0] r_ifid_pc4, r_ifid_instr;

  // ---------------- ID ----------------
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_sext, w_rd1, w_rd2, w_br_tgt, w_j_tgt;
  logic        w_regwrite, w_memtoreg, w_memread, w_memwrite, w_alusrc, w_regdst;
  logic [2:0]  w_aluop;
  logic        w_branch, w_jump, w_eq;

  // ---------------- ID/EX ----------------
  logic        r_idex_regwrite, r_idex_memtoreg, r_idex_memread, r_idex_memwrite;
  logic        r_idex_alusrc, r_idex_regdst;
  logic [2:0]  r_idex_aluop;
  logic [31:0] r_idex_rd1, r_idex_rd2, r_idex_imm;
  logic [4:0]  r_idex_rs, r_idex_rt, r_idex_rd;

  // ---------------- EX ----------------
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu;
  logic [4:0]  w_ex_dst;

  // ---------------- EX/MEM ----------------
  logic        r_exmem_regwrite, r_exmem_memtoreg, r_exmem_memwrite;
  logic [31:0] r_exmem_alu, r_exmem_wdata;
  logic [4:0]  r_exmem_dst;
  logic [31:0] w_mem_rdata;

  // ---------------- MEM/WB ----------------
  logic        r_memwb_regwrite, r_memwb_memtoreg;
  logic [31:0] r_memwb_rdata, r_memwb_alu, w_wb_data;
  logic [4:0]  r_memwb_dst;

  PC PC (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_en       (start_i & w_nostall),
    .i_redirect (w_redirect),
    .i_target   (w_target),
    .pc_o       (w_pc)
  );

  Instruction_Memory Instruction_Memory (
    .clk_i   (clk_i),
    .i_we    (1'b0),
    .i_waddr (8'd0),
    .i_wdata (32'd0),
    .i_raddr (w_pc[9:2]),
    .o_data  (w_if_instr)
  );

  // IF/ID: hold on stall, NOP on flush or when not running
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ifid_pc4   <= 32'd0;
      r_ifid_instr <= 32'd0;
    end else if (!w_nostall) begin
      r_ifid_pc4   <= r_ifid_pc4;
      r_ifid_instr <= r_ifid_instr;
    end else if (!start_i || w_redirect) begin
      r_ifid_pc4   <= 32'd0;
      r_ifid_instr <= 32'd0;
    end else begin
      r_ifid_pc4   <= w_pc + 32'd4;
      r_ifid_instr <= w_if_instr;
    end
  end

  assign w_op    = r_ifid_instr[31:26];
  assign w_rs    = r_ifid_instr[25:21];
  assign w_rt    = r_ifid_instr[20:16];
  assign w_rd    = r_ifid_instr[15:11];
  assign w_funct = r_ifid_instr[5:0];
  assign w_imm   = r_ifid_instr[15:0];
  assign w_sext  = {{16{w_imm[15]}}, w_imm};

  Control Control (
    .i_op       (w_op),
    .i_funct    (w_funct),
    .o_regwrite (w_regwrite),
    .o_memtoreg (w_memtoreg),
    .o_memread  (w_memread),
    .o_memwrite (w_memwrite),
    .o_alusrc   (w_alusrc),
    .o_regdst   (w_regdst),
    .o_aluop    (w_aluop),
    .branch_o   (w_branch),
    .jump_o     (w_jump)
  );

  // in-flight writebacks are dropped when reset hits mid-program
  Registers Registers (
    .clk_i (clk_i),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .i_we  (r_memwb_regwrite & ~rst_i),
    .i_wa  (r_memwb_dst),
    .i_wd  (w_wb_data),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  EQ EQ (
    .i_a    (w_rd1),
    .i_b    (w_rd2),
    .data_o (w_eq)
  );

  HD HD (
    .i_idex_memread (r_idex_memread),
    .i_idex_rt      (r_idex_rt),
    .i_ifid_rs      (w_rs),
    .i_ifid_rt      (w_rt),
    .mux8_o         (w_nostall)
  );

  // a stall suppresses the redirect; the branch re-evaluates after the bubble
  assign w_br_tgt   = r_ifid_pc4 + {w_sext[29:0], 2'b00};
  assign w_j_tgt    = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
  assign w_redirect = w_nostall & ((w_branch & w_eq) | w_jump);
  assign w_target   = w_jump ? w_j_tgt : w_br_tgt;

  // ID/EX: controls zeroed on stall to form a bubble
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_nostall) begin
      r_idex_regwrite <= 1'b0;
      r_idex_memtoreg <= 1'b0;
      r_idex_memread  <= 1'b0;
      r_idex_memwrite <= 1'b0;
      r_idex_alusrc   <= 1'b0;
      r_idex_regdst   <= 1'b0;
      r_idex_aluop    <= 3'd0;
    end else begin
      r_idex_regwrite <= w_regwrite;
      r_idex_memtoreg <= w_memtoreg;
      r_idex_memread  <= w_memread;
      r_idex_memwrite <= w_memwrite;
      r_idex_alusrc   <= w_alusrc;
      r_idex_regdst   <= w_regdst;
      r_idex_aluop    <= w_aluop;
    end
    if (rst_i) begin
      r_idex_rd1 <= 32'd0;
      r_idex_rd2 <= 32'd0;
      r_idex_imm <= 32'd0;
      r_idex_rs  <= 5'd0;
      r_idex_rt  <= 5'd0;
      r_idex_rd  <= 5'd0;
    end else begin
      r_idex_rd1 <= w_rd1;
      r_idex_rd2 <= w_rd2;
      r_idex_imm <= w_sext;
      r_idex_rs  <= w_rs;
      r_idex_rt  <= w_rt;
      r_idex_rd  <= w_rd;
    end
  end

  // EX operand forwarding, EX/MEM takes priority over MEM/WB
  always_comb begin
    w_fwd_a = r_idex_rd1;
    w_fwd_b = r_idex_rd2;
    if (r_exmem_regwrite && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rs)
      w_fwd_a = r_exmem_alu;
    else if (r_memwb_regwrite && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rs)
      w_fwd_a = w_wb_data;
    if (r_exmem_regwrite && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rt)
      w_fwd_b = r_exmem_alu;
    else if (r_memwb_regwrite && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rt)
      w_fwd_b = w_wb_data;
  end

  assign w_alu_b  = r_idex_alusrc ? r_idex_imm : w_fwd_b;
  assign w_ex_dst = r_idex_regdst ? r_idex_rd : r_idex_rt;

  // ALU
  always_comb begin
    case (r_idex_aluop)
      3'd1:    w_alu = w_fwd_a - w_alu_b;
      3'd2:    w_alu = w_fwd_a & w_alu_b;
      3'd3:    w_alu = w_fwd_a | w_alu_b;
      3'd4:    w_alu = w_fwd_a * w_alu_b;
      default: w_alu = w_fwd_a + w_alu_b;
    endcase
  end

  // EX/MEM register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_exmem_regwrite <= 1'b0;
      r_exmem_memtoreg <= 1'b0;
      r_exmem_memwrite <= 1'b0;
      r_exmem_alu      <= 32'd0;
      r_exmem_wdata    <= 32'd0;
      r_exmem_dst      <= 5'd0;
    end else begin
      r_exmem_regwrite <= r_idex_regwrite;
      r_exmem_memtoreg <= r_idex_memtoreg;
      r_exmem_memwrite <= r_idex_memwrite;
      r_exmem_alu      <= w_alu;
      r_exmem_wdata    <= w_fwd_b;
      r_exmem_dst      <= w_ex_dst;
    end
  end

  DATAMEMORY DATAMEMORY (
    .clk_i   (clk_i),
    .i_addr  (r_exmem_alu[4:0]),
    .i_we    (r_exmem_memwrite & ~rst_i),
    .i_wdata (r_exmem_wdata),
    .o_rdata (w_mem_rdata)
  );

  // MEM/WB register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_memwb_regwrite <= 1'b0;
      r_memwb_memtoreg <= 1'b0;
      r_memwb_rdata    <= 32'd0;
      r_memwb_alu      <= 32'd0;
      r_memwb_dst      <= 5'd0;
    end else begin
      r_memwb_regwrite <= r_exmem_regwrite;
      r_memwb_memtoreg <= r_exmem_memtoreg;
      r_memwb_rdata    <= w_mem_rdata;
      r_memwb_alu      <= r_exmem_alu;
      r_memwb_dst      <= r_exmem_dst;
    end
  end

  assign w_wb_data = r_memwb_memtoreg ? r_memwb_rdata : r_memwb_alu;
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu: programs are preloaded hierarchically,
// expected architectural state is queued up front and drained after each run.
module tb_pipelined_cpu;
  logic clk_i = 1'b0;
  logic rst_i, start_i;

  pipelined_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    int          kind;   // 0 register, 1 data-memory byte
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pclog[$];
  int vectors = 0, miscompares = 0;
  int stalls, flushes;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_reg(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = 0; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_byte(input string tag, input int idx, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.kind = 1; e.idx = idx; e.val = {24'd0, v};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == 0) obs = dut.Registers.register[e.idx];
      else             obs = {24'd0, dut.DATAMEMORY.out[e.idx]};
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
    for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'd0;
    for (int i = 0; i < 32; i++)  dut.DATAMEMORY.out[i] = 8'd0;
  endtask

  // reset edge with the program already loaded, then release and run
  task automatic go();
    rst_i = 1'b1; start_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; start_i = 1'b1;
    stalls = 0; flushes = 0;
    pclog.delete();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      if (!dut.HD.mux8_o) stalls++;
      if (dut.HD.mux8_o && ((dut.Control.branch_o && dut.EQ.data_o) || dut.Control.jump_o))
        flushes++;
      pclog.push_back(dut.PC.pc_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0;
    clear_all();

    // reset and start over NOPs
    @(posedge clk_i); #1;
    check("rst_pc", dut.PC.pc_o, 32'd0);
    rst_i = 1'b0; start_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_i); #1;
      check("pc_step", dut.PC.pc_o, 32'(4 * k));
    end
    start_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      check("pc_hold", dut.PC.pc_o, 32'd12);
    end

    // forwarding: back-to-back dependent ALU ops
    clear_all();
    dut.Instruction_Memory.memory[0] = i_type(6'h08, 5'd0, 5'd8, 16'd5);
    dut.Instruction_Memory.memory[1] = i_type(6'h08, 5'd0, 5'd9, 16'd3);
    dut.Instruction_Memory.memory[2] = r_type(5'd8, 5'd9, 5'd10, 6'h20);
    dut.Instruction_Memory.memory[3] = r_type(5'd10, 5'd8, 5'd11, 6'h22);
    expect_reg("fwd_t0", 8, 32'd5);
    expect_reg("fwd_t1", 9, 32'd3);
    expect_reg("fwd_t2", 10, 32'd8);
    expect_reg("fwd_t3", 11, 32'd3);
    go(); run(10);
    drain();
    check("fwd_stalls", 32'(stalls), 32'd0);

    // load-use: one bubble
    clear_all();
    dut.DATAMEMORY.out[0] = 8'd5;
    dut.Instruction_Memory.memory[0] = i_type(6'h23, 5'd0, 5'd8, 16'd0);
    dut.Instruction_Memory.memory[1] = r_type(5'd8, 5'd8, 5'd9, 6'h20);
    expect_reg("lu_t0", 8, 32'd5);
    expect_reg("lu_t1", 9, 32'd10);
    go(); run(10);
    drain();
    check("lu_stalls", 32'(stalls), 32'd1);

    // branch over a skipped addi, then jump past another
    clear_all();
    dut.Instruction_Memory.memory[0] = i_type(6'h04, 5'd0, 5'd0, 16'd1);
    dut.Instruction_Memory.memory[1] = i_type(6'h08, 5'd0, 5'd16, 16'd7);
    dut.Instruction_Memory.memory[2] = {6'h02, 26'd5};
    dut.Instruction_Memory.memory[3] = i_type(6'h08, 5'd0, 5'd16, 16'd7);
    dut.Instruction_Memory.memory[4] = i_type(6'h08, 5'd0, 5'd16, 16'd7);
    dut.Instruction_Memory.memory[5] = i_type(6'h08, 5'd0, 5'd17, 16'd1);
    expect_reg("br_s0", 16, 32'd0);
    expect_reg("br_s1", 17, 32'd1);
    go(); run(10);
    drain();
    check("br_flushes", 32'(flushes), 32'd2);
    check("br_pc1", pclog[1], 32'd8);
    check("br_pc3", pclog[3], 32'd20);
    check("br_pc4", pclog[4], 32'd24);

    // store then load, little-endian bytes
    clear_all();
    dut.Registers.register[8] = 32'h1234_5678;
    dut.Instruction_Memory.memory[0] = i_type(6'h2B, 5'd0, 5'd8, 16'd4);
    dut.Instruction_Memory.memory[1] = i_type(6'h23, 5'd0, 5'd9, 16'd4);
    expect_byte("sw_b4", 4, 8'h78);
    expect_byte("sw_b5", 5, 8'h56);
    expect_byte("sw_b7", 7, 8'h12);
    expect_byte("sw_b3", 3, 8'h00);
    expect_reg("lw_t1", 9, 32'h1234_5678);
    go(); run(10);
    drain();

    // mul, write to r0, unknown opcode
    clear_all();
    dut.Registers.register[8] = 32'd5;
    dut.Registers.register[9] = 32'd3;
    dut.Instruction_Memory.memory[0] = r_type(5'd8, 5'd9, 5'd17, 6'h18);
    dut.Instruction_Memory.memory[1] = i_type(6'h08, 5'd0, 5'd0, 16'd9);
    dut.Instruction_Memory.memory[2] = i_type(6'h0F, 5'd0, 5'd18, 16'd9);
    dut.Instruction_Memory.memory[3] = r_type(5'd0, 5'd17, 5'd19, 6'h20);
    expect_reg("mul_s1", 17, 32'd15);
    expect_reg("r0_zero", 0, 32'd0);
    expect_reg("nop_s2", 18, 32'd0);
    expect_reg("r0_src", 19, 32'd15);
    go(); run(10);
    drain();

    // reset mid-program discards in-flight writes
    clear_all();
    dut.Instruction_Memory.memory[0] = i_type(6'h08, 5'd0, 5'd8, 16'd1);
    dut.Instruction_Memory.memory[1] = i_type(6'h08, 5'd0, 5'd9, 16'd2);
    go(); run(4);
    rst_i = 1'b1; start_i = 1'b0;
    @(posedge clk_i); #1;
    check("mid_rst_pc", dut.PC.pc_o, 32'd0);
    rst_i = 1'b0;
    run(6);
    expect_reg("mid_rst_t0", 8, 32'd0);
    expect_reg("mid_rst_t1", 9, 32'd0);
    drain();
    check("mid_rst_pc_hold", dut.PC.pc_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
